// File: rtl/twf_cmul_stage.sv
// twf_cmul_stage
// ----------------------------------------------------------------------------
// Purpose:
//   Multiplies DEPTH parallel complex samples by a radix-8 twiddle factor
//   W8^k, one independently selected k per channel, in a two-stage pipeline
//   with valid/ready flow control.
//   Stage 1 registers the four partial products a*c, b*d, a*d, b*c.
//   Stage 2 registers the complex sums after rounding (add half an LSB, then
//   arithmetic shift right by TWF_FRAC) and reduction to DOUT_WIDTH bits.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   input beat valid
//   in_ready   out  block accepts a beat this cycle
//   tw_idx     in   DEPTH x 3 bits, per-channel twiddle index k
//   din_re     in   DEPTH x WIDTH bits, per-channel real part (signed)
//   din_im     in   DEPTH x WIDTH bits, per-channel imaginary part (signed)
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts a beat
//   dout_re    out  DEPTH x DOUT_WIDTH bits, per-channel real product
//   dout_im    out  DEPTH x DOUT_WIDTH bits, per-channel imaginary product
//
// Configuration:
//   TWF_CMUL_SAT_EN  when defined, each rounded result saturates to the
//                    DOUT_WIDTH signed range; otherwise it wraps (keeps the
//                    low DOUT_WIDTH bits).
// ----------------------------------------------------------------------------
module twf_cmul_stage #(
    parameter int WIDTH      = 11,
    parameter int TWF_WIDTH  = 10,
    parameter int TWF_FRAC   = 8,
    parameter int DOUT_WIDTH = 13,
    parameter int DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DEPTH*3-1:0]            tw_idx,
    input  logic [DEPTH*WIDTH-1:0]        din_re,
    input  logic [DEPTH*WIDTH-1:0]        din_im,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DEPTH*DOUT_WIDTH-1:0]   dout_re,
    output logic [DEPTH*DOUT_WIDTH-1:0]   dout_im
);

    // Product and sum widths chosen so that no intermediate result overflows.
    localparam int PW = WIDTH + TWF_WIDTH;
    localparam int SW = PW + 1;

    localparam logic signed [SW-1:0] ROUND_BIAS = SW'(1 <<< (TWF_FRAC - 1));

`ifdef TWF_CMUL_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DOUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DOUT_WIDTH - 1)));

    // Clamp a rounded result into the signed DOUT_WIDTH range.
    function automatic logic [DOUT_WIDTH-1:0] satReduce(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DOUT_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DOUT_WIDTH-1:0];
        end else begin
            return v[DOUT_WIDTH-1:0];
        end
    endfunction
`endif

    // W8^k real parts, Q2.8 (256 == 1.0, 181 ~= 1/sqrt(2)).
    function automatic logic signed [TWF_WIDTH-1:0] twCos(input logic [2:0] k);
        case (k)
            3'd0:    return TWF_WIDTH'(256);
            3'd1:    return TWF_WIDTH'(181);
            3'd2:    return TWF_WIDTH'(0);
            3'd3:    return TWF_WIDTH'(-181);
            3'd4:    return TWF_WIDTH'(-256);
            3'd5:    return TWF_WIDTH'(-181);
            3'd6:    return TWF_WIDTH'(0);
            default: return TWF_WIDTH'(181);
        endcase
    endfunction

    // W8^k imaginary parts, Q2.8.
    function automatic logic signed [TWF_WIDTH-1:0] twSin(input logic [2:0] k);
        case (k)
            3'd0:    return TWF_WIDTH'(0);
            3'd1:    return TWF_WIDTH'(-181);
            3'd2:    return TWF_WIDTH'(-256);
            3'd3:    return TWF_WIDTH'(-181);
            3'd4:    return TWF_WIDTH'(0);
            3'd5:    return TWF_WIDTH'(181);
            3'd6:    return TWF_WIDTH'(256);
            default: return TWF_WIDTH'(181);
        endcase
    endfunction

    logic                   valid1_q;
    logic                   valid2_q;
    logic                   advance;

    logic signed [PW-1:0]   prodAc_q [DEPTH];
    logic signed [PW-1:0]   prodBd_q [DEPTH];
    logic signed [PW-1:0]   prodAd_q [DEPTH];
    logic signed [PW-1:0]   prodBc_q [DEPTH];
    logic signed [PW-1:0]   prodAc_d [DEPTH];
    logic signed [PW-1:0]   prodBd_d [DEPTH];
    logic signed [PW-1:0]   prodAd_d [DEPTH];
    logic signed [PW-1:0]   prodBc_d [DEPTH];

    logic [DOUT_WIDTH-1:0]  doutRe_q [DEPTH];
    logic [DOUT_WIDTH-1:0]  doutIm_q [DEPTH];
    logic [DOUT_WIDTH-1:0]  doutRe_d [DEPTH];
    logic [DOUT_WIDTH-1:0]  doutIm_d [DEPTH];

    // The whole pipeline moves as one unit; it only stalls when a finished
    // beat is waiting on a busy consumer, so bubbles never block new beats.
    assign advance   = ~(valid2_q & ~out_ready);
    assign in_ready  = advance;
    assign out_valid = valid2_q;

    for (genvar ch = 0; ch < DEPTH; ch++) begin : gChan
        logic signed [WIDTH-1:0]     aIn;
        logic signed [WIDTH-1:0]     bIn;
        logic signed [TWF_WIDTH-1:0] cTw;
        logic signed [TWF_WIDTH-1:0] dTw;
        logic signed [PW-1:0]        aExt;
        logic signed [PW-1:0]        bExt;
        logic signed [PW-1:0]        cExt;
        logic signed [PW-1:0]        dExt;
        logic signed [SW-1:0]        acExt;
        logic signed [SW-1:0]        bdExt;
        logic signed [SW-1:0]        adExt;
        logic signed [SW-1:0]        bcExt;
        logic signed [SW-1:0]        sumRe;
        logic signed [SW-1:0]        sumIm;
        logic signed [SW-1:0]        roundRe;
        logic signed [SW-1:0]        roundIm;
        logic signed [SW-1:0]        shiftRe;
        logic signed [SW-1:0]        shiftIm;

        // Stage 1 operands, sign-extended to product width before multiply.
        assign aIn  = din_re[ch*WIDTH +: WIDTH];
        assign bIn  = din_im[ch*WIDTH +: WIDTH];
        assign cTw  = twCos(tw_idx[ch*3 +: 3]);
        assign dTw  = twSin(tw_idx[ch*3 +: 3]);
        assign aExt = aIn;
        assign bExt = bIn;
        assign cExt = cTw;
        assign dExt = dTw;

        assign prodAc_d[ch] = aExt * cExt;
        assign prodBd_d[ch] = bExt * dExt;
        assign prodAd_d[ch] = aExt * dExt;
        assign prodBc_d[ch] = bExt * cExt;

        // Stage 2: one extra bit for the sum, then round half toward +inf.
        assign acExt   = prodAc_q[ch];
        assign bdExt   = prodBd_q[ch];
        assign adExt   = prodAd_q[ch];
        assign bcExt   = prodBc_q[ch];
        assign sumRe   = acExt - bdExt;
        assign sumIm   = adExt + bcExt;
        assign roundRe = sumRe + ROUND_BIAS;
        assign roundIm = sumIm + ROUND_BIAS;
        assign shiftRe = roundRe >>> TWF_FRAC;
        assign shiftIm = roundIm >>> TWF_FRAC;

`ifdef TWF_CMUL_SAT_EN
        assign doutRe_d[ch] = satReduce(shiftRe);
        assign doutIm_d[ch] = satReduce(shiftIm);
`else
        assign doutRe_d[ch] = DOUT_WIDTH'(shiftRe);
        assign doutIm_d[ch] = DOUT_WIDTH'(shiftIm);
`endif

        assign dout_re[ch*DOUT_WIDTH +: DOUT_WIDTH] = doutRe_q[ch];
        assign dout_im[ch*DOUT_WIDTH +: DOUT_WIDTH] = doutIm_q[ch];
    end

    // Pipeline registers. Reset empties the pipe and zeroes all data so that
    // beats in flight are discarded and outputs read 0 straight away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                prodAc_q[i] <= '0;
                prodBd_q[i] <= '0;
                prodAd_q[i] <= '0;
                prodBc_q[i] <= '0;
                doutRe_q[i] <= '0;
                doutIm_q[i] <= '0;
            end
        end else if (advance) begin
            valid1_q <= in_valid;
            valid2_q <= valid1_q;
            for (int i = 0; i < DEPTH; i++) begin
                prodAc_q[i] <= prodAc_d[i];
                prodBd_q[i] <= prodBd_d[i];
                prodAd_q[i] <= prodAd_d[i];
                prodBc_q[i] <= prodBc_d[i];
                doutRe_q[i] <= doutRe_d[i];
                doutIm_q[i] <= doutIm_d[i];
            end
        end
    end

endmodule

// File: doc/twf_cmul_stage.md
TWF_CMUL_STAGE -- requirements
Module: twf_cmul_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 11, input sample width, signed Q5.6.
REQ-002 SHALL have parameter TWF_WIDTH, default 10, twiddle width, signed Q2.8.
REQ-003 SHALL have parameter TWF_FRAC, default 8, twiddle fraction bits and product right-shift amount.
REQ-004 SHALL have parameter DOUT_WIDTH, default 13, output width, signed.
REQ-005 SHALL have parameter DEPTH, default 16, parallel channel count.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port in_valid  input  1  input beat valid.
REQ-009 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-010 SHALL have port tw_idx  input  DEPTH x 3  per-channel twiddle index k, selecting W8^k.
REQ-011 SHALL have port din_re / din_im  input  DEPTH x WIDTH  per-channel complex sample.
REQ-012 SHALL have port out_valid  output  1  output beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts a beat.
REQ-014 SHALL have port dout_re / dout_im  output  DEPTH x DOUT_WIDTH  per-channel complex product.

Function
REQ-015 SHALL compute, per channel, (din_re + j*din_im) * W8^k as a full complex multiply: re = a*c - b*d, im = a*d + b*c.
REQ-016 SHALL use twiddle constants (c,d) for k = 0..7: (256,0) (181,-181) (0,-256) (-181,-181) (-256,0) (-181,181) (0,256) (181,181).
REQ-017 SHALL form products at WIDTH+TWF_WIDTH bits and sums at WIDTH+TWF_WIDTH+1 bits, with no intermediate overflow.
REQ-018 SHALL round each sum by adding 2^(TWF_FRAC-1) and then arithmetic-shifting right by TWF_FRAC (round half toward +inf).
REQ-019 SHALL use a 2-stage pipeline: stage 1 registers the four products and the valid bit; stage 2 registers sum, round and width reduction.
REQ-020 SHALL produce output with a latency of exactly 2 cycles from an accepted beat (in_valid & in_ready) to out_valid, absent stalls.
REQ-021 SHALL drive in_ready = ~(out_valid & ~out_ready), combinational.
REQ-022 SHALL freeze both stages, including valid bits, while out_valid=1 and out_ready=0; dout_* and out_valid then hold stable.
REQ-023 SHALL let bubbles (in_valid=0) propagate as out_valid=0 without blocking later beats.
REQ-024 SHALL sustain full throughput of one beat per cycle while out_ready=1.
REQ-025 SHALL keep every channel's tw_idx independent and capture it with its beat.

Reset
REQ-026 SHALL clear both pipeline valid bits, all product registers, dout_re and dout_im to 0 while rst=1.
REQ-027 SHALL discard in-flight beats when rst is asserted mid-operation; out_valid SHALL be 0 from the reset edge onward.
REQ-028 SHALL allow the first beat presented after rst deasserts to be accepted, giving out_valid 2 cycles later.

Configuration
REQ-029 SHALL, with macro TWF_CMUL_SAT_EN defined, saturate each rounded result to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
REQ-030 SHALL, without TWF_CMUL_SAT_EN, truncate each rounded result to its low DOUT_WIDTH bits (two's-complement wrap).

Verification
REQ-031 SHALL cover: k=0, din=(100,-50) -> dout=(100,-50), out_valid 2 cycles after acceptance.
REQ-032 SHALL cover: k=2, din=(100,-50) -> dout=(-50,-100); k=1, din=(100,0) -> dout=(71,-71).
REQ-033 SHALL cover: DOUT_WIDTH=11, k=1, din=(-1024,-1024) -> dout_re=-1024 with TWF_CMUL_SAT_EN, 600 without.
REQ-034 SHALL cover: stream 8 beats back-to-back with out_ready held low for 3 cycles mid-stream -> in_ready=0 and dout held during the stall, all 8 results delivered in order with none lost or duplicated.
REQ-035 SHALL cover: rst pulsed with 2 beats in flight -> out_valid=0 and dout=0 immediately; the next beat completes with 2-cycle latency.
REQ-036 SHALL cover: all 16 channels given distinct k and random samples -> each channel matches the reference model bit-exactly.
